// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage write scoreboard; stalls fetch/decode on RAW or counter-full hazards, flushes IF/ID on a taken branch. Optional macro: HAZARD_CTRL_FORWARD_EN.
// Latency: hazard to stall is 0 cycles; a retire releases a stall the next cycle (the same cycle with forwarding).
// Backpressure: pc_en/ir_en low and id_bubble high while stalled; deadlock is flagged after STALL_MAX consecutive stall cycles.
module hazard_ctrl #(
    parameter int NREG      = 16,
    parameter int CNT_W     = 2,
    parameter int FLUSH_CYC = 1,
    parameter int STALL_MAX = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic [3:0] id_rd,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_regwrite,
    input  logic       wb_regwrite,
    input  logic [3:0] wb_rd,
    input  logic       br_taken,
    output logic       pc_en,
    output logic       ir_en,
    output logic       id_bubble,
    output logic       if_flush,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       busy,
    output logic       sb_err,
    output logic       deadlock
);
    localparam int SCNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t            state;
    logic [3:0]        fcnt;
    logic [SCNT_W-1:0] scnt;
    logic [CNT_W-1:0]  pend [NREG];

    logic byp1, byp2, raw, full, stall_cond, advance, issue, retire;

    always_comb begin
`ifdef HAZARD_CTRL_FORWARD_EN
        // a single outstanding write retiring now can be taken straight from the wb bus
        byp1 = wb_regwrite && (wb_rd == id_rs1) && (pend[id_rs1] == CNT_W'(1));
        byp2 = wb_regwrite && (wb_rd == id_rs2) && (pend[id_rs2] == CNT_W'(1));
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        raw = id_valid && ((id_use_rs1 && (pend[id_rs1] != '0) && !byp1) ||
                           (id_use_rs2 && (pend[id_rs2] != '0) && !byp2));
        full       = id_valid && id_regwrite && (pend[id_rd] == CNT_MAX);
        stall_cond = raw || full;

        pc_en     = 1'b1;
        ir_en     = 1'b1;
        id_bubble = 1'b0;
        if_flush  = 1'b0;
        advance   = 1'b0;
        if (br_taken) begin
            if_flush  = 1'b1;
            id_bubble = 1'b1;
        end else if (state == FLUSH) begin
            id_bubble = 1'b1;
        end else if (stall_cond) begin
            pc_en     = 1'b0;
            ir_en     = 1'b0;
            id_bubble = 1'b1;
        end else begin
            advance = 1'b1;
        end

        issue  = advance && id_valid && id_regwrite && (id_rd != 4'd0);
        retire = wb_regwrite && (wb_rd != 4'd0);

`ifdef HAZARD_CTRL_FORWARD_EN
        fwd_a = advance && id_valid && byp1 && id_use_rs1 && (id_rs1 != 4'd0);
        fwd_b = advance && id_valid && byp2 && id_use_rs2 && (id_rs2 != 4'd0);
`else
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`endif

        busy = 1'b0;
        for (int i = 0; i < NREG; i++) busy = busy | (pend[i] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fcnt     <= 4'd0;
            scnt     <= '0;
            sb_err   <= 1'b0;
            deadlock <= 1'b0;
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else begin
            if (br_taken) begin
                state <= (FLUSH_CYC > 1) ? FLUSH : RUN;
                fcnt  <= 4'(FLUSH_CYC - 1);
            end else if (state == FLUSH) begin
                fcnt <= fcnt - 4'd1;
                if (fcnt <= 4'd1) state <= RUN;
            end else begin
                state <= stall_cond ? STALL : RUN;
            end

            // register 0 is never counted, so the loop skips it
            for (int i = 1; i < NREG; i++) begin
                if (issue && (id_rd == 4'(i)) && !(retire && (wb_rd == 4'(i))))
                    pend[i] <= pend[i] + CNT_W'(1);
                else if (retire && (wb_rd == 4'(i)) && !(issue && (id_rd == 4'(i))) && (pend[i] != '0))
                    pend[i] <= pend[i] - CNT_W'(1);
            end
            if (retire && (pend[wb_rd] == '0)) sb_err <= 1'b1;

            if (stall_cond) begin
                if (scnt != SCNT_W'(STALL_MAX)) scnt <= scnt + SCNT_W'(1);
                if (scnt >= SCNT_W'(STALL_MAX - 1)) deadlock <= 1'b1;
            end else begin
                scnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written corner sequences, then random stimulus
// compared every cycle against a counter-based reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    localparam int FC   = 2;
    localparam int MAXC = 3;
    localparam int SMAX = 64;
`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, wb_regwrite, br_taken;
    logic [3:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic pc_en, ir_en, id_bubble, if_flush, fwd_a, fwd_b, busy, sb_err, deadlock;
    logic [8:0] outs;

    hazard_ctrl #(.FLUSH_CYC(FC)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .br_taken(br_taken), .pc_en(pc_en), .ir_en(ir_en), .id_bubble(id_bubble),
        .if_flush(if_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy),
        .sb_err(sb_err), .deadlock(deadlock)
    );

    always #5 clk = ~clk;
    assign outs = {pc_en, ir_en, id_bubble, if_flush, fwd_a, fwd_b, busy, sb_err, deadlock};

    typedef struct packed {
        logic vld; logic [3:0] rs1, rs2, rd; logic u1, u2, rw, wbw; logic [3:0] wbrd; logic br;
    } in_t;
    typedef struct { in_t v; logic [8:0] exp; } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model: outstanding-write counts and remaining bubble cycles
    int pend_m [16];
    int flush_left, stall_run;
    bit sb_m, dl_m;

    function automatic in_t instr(logic [15:0] ir, logic u1, logic u2, logic rw);
        in_t t = '0;
        t.vld = 1'b1; t.rs2 = ir[15:12]; t.rs1 = ir[11:8]; t.rd = ir[7:4];
        t.u1 = u1; t.u2 = u2; t.rw = rw;
        return t;
    endfunction

    function automatic in_t with_wb(in_t t, logic [3:0] r);
        t.wbw = 1'b1; t.wbrd = r;
        return t;
    endfunction

    task automatic drive(in_t v);
        id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_regwrite = v.rw;
        wb_regwrite = v.wbw; wb_rd = v.wbrd; br_taken = v.br;
    endtask

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 0;
        flush_left = 0; stall_run = 0; sb_m = 1'b0; dl_m = 1'b0;
    endtask

    task automatic model_eval(input in_t v, output logic [8:0] o, output bit adv, output bit stl);
        bit b1, b2, raw, full, pc, ir, bub, fl, fa, fb, bsy;
        b1   = FWD && v.wbw && (v.wbrd == v.rs1) && (pend_m[v.rs1] == 1);
        b2   = FWD && v.wbw && (v.wbrd == v.rs2) && (pend_m[v.rs2] == 1);
        raw  = v.vld && ((v.u1 && pend_m[v.rs1] != 0 && !b1) || (v.u2 && pend_m[v.rs2] != 0 && !b2));
        full = v.vld && v.rw && (pend_m[v.rd] == MAXC);
        stl  = raw || full;
        adv = 0; pc = 1; ir = 1; bub = 0; fl = 0;
        if (v.br) begin bub = 1; fl = 1; end
        else if (flush_left > 0) bub = 1;
        else if (stl) begin pc = 0; ir = 0; bub = 1; end
        else adv = 1;
        fa = adv && v.vld && b1 && v.u1 && (v.rs1 != 0);
        fb = adv && v.vld && b2 && v.u2 && (v.rs2 != 0);
        bsy = 0;
        foreach (pend_m[i]) if (pend_m[i] > 0) bsy = 1;
        o = {pc, ir, bub, fl, fa, fb, bsy, sb_m, dl_m};
    endtask

    task automatic model_step(in_t v, bit adv, bit stl);
        bit ret;
        ret = v.wbw && (v.wbrd != 0);
        if (ret && pend_m[v.wbrd] == 0) sb_m = 1'b1;
        if (adv && v.vld && v.rw && v.rd != 0) pend_m[v.rd]++;
        if (ret && pend_m[v.wbrd] > 0) pend_m[v.wbrd]--;
        if (stl) begin
            if (stall_run < SMAX) stall_run++;
            if (stall_run >= SMAX) dl_m = 1'b1;
        end else begin
            stall_run = 0;
        end
        if (v.br) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
    endtask

    task automatic check(string what, logic [8:0] got, logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b {pc_en,ir_en,bubble,flush,fwd_a,fwd_b,busy,sb_err,deadlock} t=%0t",
                     what, got, exp, $time);
        end
    endtask

    task automatic cyc(in_t v, string what, bit has_exp, logic [8:0] exp);
        logic [8:0] m;
        bit adv, stl;
        @(negedge clk);
        rst = 1'b0;
        drive(v);
        #1;
        model_eval(v, m, adv, stl);
        check({what, "/model"}, outs, m);
        if (has_exp) check(what, outs, exp);
        model_step(v, adv, stl);
    endtask

    task automatic do_reset(int n, in_t v);
        @(negedge clk);
        rst = 1'b1;
        drive(v);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    in_t  idle, t, rd5, w3, r8;
    vec_t tbl [7];
    int   r;

    initial begin
        idle = '0;
        rst  = 1'b1;
        drive(idle);
        model_reset();
        do_reset(2, idle);

        tbl[0] = '{instr(16'h2160, 1, 1, 1), 9'b110000000};
        tbl[1] = '{instr(16'h0670, 1, 0, 0), 9'b001000100};
        tbl[2] = '{instr(16'h0670, 1, 0, 0), 9'b001000100};
        tbl[3] = '{with_wb(instr(16'h0670, 1, 0, 0), 4'd6), FWD ? 9'b110010100 : 9'b001000100};
        tbl[4] = '{instr(16'h0670, 1, 0, 0), 9'b110000000};
        tbl[5] = '{instr(16'h0000, 1, 1, 1), 9'b110000000};
        tbl[6] = '{idle, 9'b110000000};
        for (int i = 0; i < 7; i++) cyc(tbl[i].v, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);

        // branch taken while stalled, two bubble cycles
        cyc(instr(16'h0050, 0, 0, 1), "a_issue5", 1'b1, 9'b110000000);
        rd5 = instr(16'h0580, 1, 0, 0);
        cyc(rd5, "a_stall", 1'b1, 9'b001000100);
        t = rd5; t.br = 1'b1;
        cyc(t, "a_branch", 1'b1, 9'b111100100);
        cyc(rd5, "a_flush", 1'b1, 9'b111000100);
        cyc(idle, "a_run", 1'b1, 9'b110000100);
        cyc(with_wb(idle, 4'd5), "a_retire", 1'b1, 9'b110000100);

        // counter saturation on r3
        w3 = instr(16'h0030, 0, 0, 1);
        cyc(w3, "b_w1", 1'b1, 9'b110000000);
        cyc(w3, "b_w2", 1'b1, 9'b110000100);
        cyc(w3, "b_w3", 1'b1, 9'b110000100);
        cyc(w3, "b_full", 1'b1, 9'b001000100);
        cyc(with_wb(w3, 4'd3), "b_full_ret", 1'b1, 9'b001000100);
        cyc(w3, "b_issue", 1'b1, 9'b110000100);
        cyc(w3, "b_full2", 1'b1, 9'b001000100);
        for (int i = 0; i < 3; i++) cyc(with_wb(idle, 4'd3), "b_drain", 1'b1, 9'b110000100);
        cyc(idle, "b_empty", 1'b1, 9'b110000000);

        // retire without outstanding write; r0 reader
        cyc(with_wb(idle, 4'd9), "c_bad_ret", 1'b1, 9'b110000000);
        cyc(instr(16'h0000, 1, 1, 0), "c_r0_read", 1'b1, 9'b110000010);

        // long RAW stall into deadlock, then reset while still stalled
        cyc(instr(16'h0080, 0, 0, 1), "d_issue8", 1'b1, 9'b110000010);
        r8 = instr(16'h0890, 1, 0, 0);
        for (int i = 0; i < SMAX + 3; i++)
            cyc(r8, (i < SMAX) ? "d_stall" : "d_deadlock", 1'b1,
                (i < SMAX) ? 9'b001000110 : 9'b001000111);
        do_reset(1, r8);
        cyc(r8, "d_after_rst", 1'b1, 9'b110000000);

        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) do_reset(1 + (n % 2), idle);
            t = '0;
            t.vld = ($urandom_range(0, 9) != 0);
            t.rs1 = 4'($urandom_range(0, 5));
            t.rs2 = 4'($urandom_range(0, 5));
            t.rd  = 4'($urandom_range(0, 5));
            t.u1  = 1'($urandom_range(0, 1));
            t.u2  = 1'($urandom_range(0, 1));
            t.rw  = 1'($urandom_range(0, 1));
            r = $urandom_range(1, 5);
            if ((pend_m[r] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0)) begin
                t.wbw = 1'b1; t.wbrd = 4'(r);
            end
            t.br = ($urandom_range(0, 24) == 0);
            cyc(t, "rand", 1'b0, 9'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
